ibex_fetch_req_ctrl: RTL

Sequences instruction-bus requests for the IF stage prefetch path. Issues word-aligned fetches and holds address stability until grant. Tracks outstanding requests against a limit and against downstream FIFO space. On a branch redirect, drops stale responses so the fetch FIFO only ever sees in-order, valid words from the current stream.

---
 rtl/ibex_fetch_req_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
// IF-stage prefetch request sequencer: issues word-aligned instruction-bus
// requests, bounds outstanding traffic and drops responses made stale by a redirect.

module ibex_fetch_req_ctrl_sva #(
  parameter int unsigned NumOutstanding = 2,
  parameter int unsigned CntW           = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [CntW-1:0] out_q_i,
  input  logic [CntW-1:0] disc_q_i,
  input  logic            retire_i,
  input  logic            instr_req_i,
  input  logic            instr_gnt_i,
  input  logic [31:0]     instr_addr_i
);

  localparam logic [CntW-1:0] MaxOut = CntW'(NumOutstanding);

  a_no_orphan_retire: assert property (@(posedge clk_i) disable iff (!rst_ni)
    retire_i |-> (out_q_i != {CntW{1'b0}}));

  a_out_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_q_i <= MaxOut);

  a_disc_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    disc_q_i <= out_q_i);

  a_addr_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_addr_i[1:0] == 2'b00);

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (instr_req_i && !instr_gnt_i) |=> (instr_req_i && $stable(instr_addr_i)));

endmodule

module ibex_fetch_req_ctrl #(
  parameter int unsigned NumOutstanding = 2,
  localparam int unsigned CntW = $clog2(NumOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [31:0]     boot_addr_i,
  input  logic            req_i,
  input  logic            branch_i,
  input  logic [31:0]     branch_addr_i,
  input  logic [CntW-1:0] fifo_space_i,
  output logic            instr_req_o,
  output logic [31:0]     instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic            instr_bus_err_i,
  output logic            resp_valid_o,
  output logic            resp_err_o,
  output logic [31:0]     resp_addr_o,
  output logic            busy_o
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } state_e;

  localparam logic [CntW-1:0] MaxOut = CntW'(NumOutstanding);

  state_e          state_q, state_d;
  logic [CntW-1:0] out_q, out_d;
  logic [CntW-1:0] disc_q, disc_d;
  logic            branch_pend_q, branch_pend_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d;
  logic [31:0]     resp_addr_q, resp_addr_d;
  logic [31:0]     branch_addr_q, branch_addr_d;

  logic [31:0]     branch_tgt_s;
  logic [31:0]     boot_fetch_s;
  logic [CntW-1:0] in_fifo_s;
  logic            can_issue_s;
  logic            req_s;
  logic            issue_s;
  logic            retire_s;
  logic            resp_valid_s;
  logic            unused_addr_bits_s;

  assign branch_tgt_s       = {branch_addr_i[31:2], 2'b00};
  assign boot_fetch_s       = {boot_addr_i[31:8], 8'h80};
  assign unused_addr_bits_s = ^{boot_addr_i[7:0], branch_addr_i[1:0]};

  // Words still owed to the FIFO exclude the ones that will be discarded.
  assign in_fifo_s    = out_q - disc_q;
  assign can_issue_s  = (out_q < MaxOut) && (fifo_space_i > in_fifo_s);
  assign issue_s      = req_s & instr_gnt_i;
  assign retire_s     = instr_rvalid_i;
  assign resp_valid_s = rst_ni & retire_s & (disc_q == {CntW{1'b0}}) & ~branch_i;

  // Bus request: a held request never depends on grant or redirect.
  always_comb begin
    req_s = 1'b0;
    case (state_q)
      IDLE:     req_s = rst_ni & req_i & can_issue_s & ~branch_i;
      WAIT_GNT: req_s = rst_ni;
      default:  req_s = 1'b0;
    endcase
  end

  // Fetch address sequencing and the redirect held back behind a pending grant.
  always_comb begin
    state_d       = state_q;
    fetch_addr_d  = fetch_addr_q;
    branch_pend_d = branch_pend_q;
    branch_addr_d = branch_addr_q;
    case (state_q)
      IDLE: begin
        if (branch_i) begin
          fetch_addr_d = branch_tgt_s;
        end else if (issue_s) begin
          fetch_addr_d = fetch_addr_q + 32'd4;
        end else if (req_s) begin
          state_d = WAIT_GNT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_GNT: begin
        if (issue_s) begin
          state_d       = IDLE;
          branch_pend_d = 1'b0;
          if (branch_i) begin
            fetch_addr_d = branch_tgt_s;
          end else if (branch_pend_q) begin
            fetch_addr_d = branch_addr_q;
          end else begin
            fetch_addr_d = fetch_addr_q + 32'd4;
          end
        end else if (branch_i) begin
          branch_pend_d = 1'b1;
          branch_addr_d = branch_tgt_s;
        end else begin
          state_d = WAIT_GNT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outstanding / discard accounting; a redirect marks every in-flight word stale.
  always_comb begin
    out_d  = out_q + CntW'(issue_s) - CntW'(retire_s);
    disc_d = disc_q;
    if (branch_i || (issue_s && branch_pend_q)) begin
      disc_d = out_d;
    end else if (retire_s && (disc_q != {CntW{1'b0}})) begin
      disc_d = disc_q - CntW'(1'b1);
    end else begin
      disc_d = disc_q;
    end
  end

  // Address tag for the next word handed to the FIFO.
  always_comb begin
    resp_addr_d = resp_addr_q;
    if (branch_i) begin
      resp_addr_d = branch_tgt_s;
    end else if (resp_valid_s) begin
      resp_addr_d = resp_addr_q + 32'd4;
    end else begin
      resp_addr_d = resp_addr_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      out_q         <= {CntW{1'b0}};
      disc_q        <= {CntW{1'b0}};
      branch_pend_q <= 1'b0;
      fetch_addr_q  <= boot_fetch_s;
      resp_addr_q   <= boot_fetch_s;
      branch_addr_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      out_q         <= out_d;
      disc_q        <= disc_d;
      branch_pend_q <= branch_pend_d;
      fetch_addr_q  <= fetch_addr_d;
      resp_addr_q   <= resp_addr_d;
      branch_addr_q <= branch_addr_d;
    end
  end

  assign instr_req_o  = req_s;
  assign instr_addr_o = fetch_addr_q;
  assign resp_valid_o = resp_valid_s;
  assign resp_err_o   = resp_valid_s & instr_bus_err_i;
  assign resp_addr_o  = resp_addr_q;
  assign busy_o       = rst_ni & ((state_q == WAIT_GNT) | (out_q != {CntW{1'b0}}));

  ibex_fetch_req_ctrl_sva #(
    .NumOutstanding (NumOutstanding),
    .CntW           (CntW)
  ) u_sva (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .out_q_i      (out_q),
    .disc_q_i     (disc_q),
    .retire_i     (retire_s),
    .instr_req_i  (req_s),
    .instr_gnt_i  (instr_gnt_i),
    .instr_addr_i (fetch_addr_q)
  );

endmodule
